ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 16x8 synchronous RAM. It shares the single RAM port between two requesters, port 0 (instruction fetch) and port 1 (data access). It serializes their read and write transactions into correctly timed `read`/`write`/`addr`/`data_in` pulses and returns read data with a one-cycle acknowledge. It sits between the CPU control unit and the RAM; it is the only driver of the RAM control inputs.

---
 rtl/ram_arb_pkg.sv | 16 +
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/ram_arb_pick.sv | 34 +++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int RAM_ADDR_W = 4;
    localparam int RAM_DATA_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes plus the RAM control bus.
// slave is the arbiter's view; master is the view of the CPU side and RAM.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection between the two requesters.
// RAM_ARB_RR_EN selects round-robin on contention; otherwise port 0 has
// fixed priority and the last input is ignored.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic vld
);

`ifndef RAM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    // Pick a winner among the pending requests.
    always_comb begin
        vld = req0 | req1;
        win = PORT0;
`ifdef RAM_ARB_RR_EN
        if (req0 && req1)
            win = (last == PORT0) ? PORT1 : PORT0;
        else if (req1)
            win = PORT1;
`else
        if (!req0 && req1)
            win = PORT1;
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port between instruction fetch (port 0)
// and data access (port 1). Each transaction runs IDLE -> ACCESS -> RESP and
// is acknowledged in the cycle after RESP, when the FSM is already back in
// IDLE and may grant again. Macro RAM_ARB_RR_EN enables round-robin; without
// it port 0 wins every contention.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);

    state_t            state_q;
    logic              port_q;
    logic              mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              busy_q;

    logic              last;
    logic              pick_win, pick_vld;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    ram_arb_pick u_pick (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (last),
        .win  (pick_win),
        .vld  (pick_vld)
    );

    // Winner's request fields, latched at the grant edge.
    assign we_d    = (pick_win == PORT1) ? bus.we1    : bus.we0;
    assign addr_d  = (pick_win == PORT1) ? bus.addr1  : bus.addr0;
    assign wdata_d = (pick_win == PORT1) ? bus.wdata1 : bus.wdata0;

`ifdef RAM_ARB_RR_EN
    logic last_q;

    // Remember the most recent grant; reset favours port 0 on first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= PORT1;
        else if (state_q == IDLE && pick_vld)
            last_q <= pick_win;
    end

    assign last = last_q;
`else
    assign last = PORT1;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= PORT0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        port_q      <= pick_win;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        mem_write_q <= we_d;
                        mem_read_q  <= ~we_d;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM samples the controls at the end of ACCESS.
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    // RAM output is valid now; for writes it is don't-care.
                    if (port_q == PORT1) begin
                        rdata1_q <= bus.mem_rdata;
                        ack1_q   <= 1'b1;
                    end else begin
                        rdata0_q <= bus.mem_rdata;
                        ack0_q   <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized scoreboard bench for ram_arbiter with a 16x8
// synchronous RAM model. Each round is planned by a transaction-level model
// (service order, ack cycle, read data) and checked by an ack monitor.
module tb_ram_arbiter;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } tx_t;

    typedef struct {
        int         cyc;
        bit         rd;
        logic [7:0] d;
        logic [7:0] alt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, write at the clock edge.
    logic [7:0] ram [16];
    logic [7:0] ram_dout = 8'h00;
    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  ram_dout <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = ram_dout;

    // Reference state.
    logic [7:0] shadow [16];
    logic       m_last = 1'b1;
    bit         unsure = 0;
    logic [3:0] unsure_addr = 4'd0;
    logic [7:0] unsure_val = 8'd0;
    exp_t       q0 [$];
    exp_t       q1 [$];
    tx_t        tx0 [4];
    tx_t        tx1 [4];

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    // Ack monitor: pops the scoreboard on each acknowledge.
    exp_t e0, e1;
    always @(negedge clk) begin
        if (bus.ack0 || bus.ack1)
            chk(!(bus.ack0 && bus.ack1), "dual_ack", {bus.ack1, bus.ack0}, 0);
        if (bus.mem_read && bus.mem_write)
            chk(0, "rd_wr_both", 3, 0);
        if (bus.ack0) begin
            if (q0.size() == 0) chk(0, "unexpected_ack0", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk(cyc == e0.cyc, "ack0_cycle", cyc, e0.cyc);
                if (e0.rd)
                    chk(bus.rdata0 == e0.d || bus.rdata0 == e0.alt, "rdata0", bus.rdata0, e0.d);
            end
        end
        if (bus.ack1) begin
            if (q1.size() == 0) chk(0, "unexpected_ack1", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk(cyc == e1.cyc, "ack1_cycle", cyc, e1.cyc);
                if (e1.rd)
                    chk(bus.rdata1 == e1.d || bus.rdata1 == e1.alt, "rdata1", bus.rdata1, e1.d);
            end
        end
    end

    function automatic tx_t rnd_tx();
        tx_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = 4'($urandom_range(0, 15));
        t.wdata = 8'($urandom_range(0, 255));
        return t;
    endfunction

    // One round: both ports start requesting in the same cycle; port N issues
    // nN transactions back to back, holding req until its last ack.
    task automatic run_round(input int n0, input int n1);
        int   rem0, rem1, i0, i1, t, c0, k0, k1, guard;
        logic w;
        tx_t  tx, first;
        exp_t e;
        @(posedge clk); #1;
        c0 = cyc;
        rem0 = n0; rem1 = n1; i0 = 0; i1 = 0; t = c0;
        first = '0;
        while (rem0 + rem1 > 0) begin
            if (rem0 > 0 && rem1 > 0) begin
`ifdef RAM_ARB_RR_EN
                w = (m_last == 1'b0);
`else
                w = 1'b0;
`endif
            end else begin
                w = (rem1 > 0);
            end
            tx = w ? tx1[i1] : tx0[i0];
            if (t == c0) first = tx;
            e.cyc = t + 3;
            e.rd  = !tx.we;
            e.d   = shadow[tx.addr];
            e.alt = (unsure && tx.addr == unsure_addr) ? unsure_val : e.d;
            if (tx.we) begin
                shadow[tx.addr] = tx.wdata;
                if (tx.addr == unsure_addr) unsure = 0;
            end
            if (w) begin q1.push_back(e); rem1--; i1++; end
            else   begin q0.push_back(e); rem0--; i0++; end
            m_last = w;
            t += 3;
        end
        k0 = 0; k1 = 0;
        bus.req0 = (n0 > 0); bus.we0 = tx0[0].we; bus.addr0 = tx0[0].addr; bus.wdata0 = tx0[0].wdata;
        bus.req1 = (n1 > 0); bus.we1 = tx1[0].we; bus.addr1 = tx1[0].addr; bus.wdata1 = tx1[0].wdata;
        guard = 0;
        while ((k0 < n0 || k1 < n1) && guard < 40) begin
            @(posedge clk); #1;
            guard++;
            if (cyc == c0 + 1)
                chk(bus.busy && bus.mem_write == first.we && bus.mem_read == !first.we &&
                    bus.mem_addr == first.addr && (!first.we || bus.mem_wdata == first.wdata),
                    "access_ctrl", {bus.busy, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata},
                    {1'b1, !first.we, first.we, first.addr, first.wdata});
            if (bus.ack0 || bus.ack1)
                chk(!bus.busy, "busy_in_ack", bus.busy, 0);
            if (bus.ack0) begin
                k0++;
                if (k0 < n0) begin
                    bus.we0 = tx0[k0].we; bus.addr0 = tx0[k0].addr; bus.wdata0 = tx0[k0].wdata;
                end else bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                k1++;
                if (k1 < n1) begin
                    bus.we1 = tx1[k1].we; bus.addr1 = tx1[k1].addr; bus.wdata1 = tx1[k1].wdata;
                end else bus.req1 = 1'b0;
            end
        end
        if (k0 < n0 || k1 < n1) begin
            chk(0, "round_timeout", k0 + k1, n0 + n1);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            @(negedge clk);
            q0.delete(); q1.delete();
        end
    endtask

    function automatic bit outs_zero();
        return !bus.ack0 && !bus.ack1 && !bus.busy && !bus.mem_read && !bus.mem_write &&
               bus.mem_addr == 4'd0 && bus.mem_wdata == 8'd0 &&
               bus.rdata0 == 8'd0 && bus.rdata1 == 8'd0;
    endfunction

    initial begin
        logic [7:0] old5;
        for (int i = 0; i < 16; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        repeat (3) @(posedge clk);
        #1 chk(outs_zero(), "reset_outputs", {bus.busy, bus.ack0, bus.ack1}, 0);
        rst = 1'b0;

        // Write then read through different ports.
        tx1[0] = '{we: 1'b1, addr: 4'd3, wdata: 8'hA5};
        run_round(0, 1);
        tx0[0] = '{we: 1'b0, addr: 4'd3, wdata: 8'h00};
        run_round(1, 0);

        // Contention, both reads.
        tx0[0] = '{we: 1'b0, addr: 4'd3, wdata: 8'h11};
        tx1[0] = '{we: 1'b0, addr: 4'd7, wdata: 8'h22};
        run_round(1, 1);

        // Continuous requests from both ports.
        for (int i = 0; i < 2; i++) begin tx0[i] = rnd_tx(); tx1[i] = rnd_tx(); end
        run_round(2, 2);

        // Back-to-back on port 0.
        tx0[0] = '{we: 1'b1, addr: 4'd9, wdata: 8'h5A};
        tx0[1] = '{we: 1'b0, addr: 4'd9, wdata: 8'h00};
        run_round(2, 0);

        // Reset during an ACCESS write.
        old5 = shadow[5];
        @(posedge clk); #1;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd5; bus.wdata1 = 8'h3C;
        @(posedge clk); #1;
        chk(bus.mem_write && bus.busy, "pre_reset_access", {bus.busy, bus.mem_write}, 3);
        #2 rst = 1'b1;
        #1 chk(outs_zero(), "reset_mid_access", {bus.busy, bus.mem_write, bus.mem_addr}, 0);
        bus.req1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last = 1'b1;
        unsure = 1; unsure_addr = 4'd5; unsure_val = 8'h3C;
        shadow[5] = old5;

        // First contention after reset, port 0 reads the aborted address.
        tx0[0] = '{we: 1'b0, addr: 4'd5, wdata: 8'h00};
        tx1[0] = '{we: 1'b0, addr: 4'd2, wdata: 8'h00};
        run_round(1, 1);
        tx0[0] = '{we: 1'b1, addr: 4'd5, wdata: 8'hC3};
        run_round(1, 0);

        // Randomized rounds.
        for (int r = 0; r < 60; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n0 = 1;
            for (int i = 0; i < 4; i++) begin tx0[i] = rnd_tx(); tx1[i] = rnd_tx(); end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_round(n0, n1);
        end

        repeat (5) @(posedge clk);
        #1 chk(q0.size() == 0 && q1.size() == 0, "scoreboard_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
